// File: rtl/ext_mem_frame_reader.sv
// Raster-order window reader for the external pixel memory. It issues one read per
// cycle under credit control and streams pixels with frame and line markers.
module ext_mem_frame_reader #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int DIM_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_height,
    input  logic [ADDR_W-1:0] cfg_stride,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic              sof;
        logic              eol;
        logic              eof;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [DIM_W-1:0]  width_q, width_d;
    logic [DIM_W-1:0]  height_q, height_d;
    logic [DIM_W-1:0]  x_q, x_d;
    logic [DIM_W-1:0]  y_q, y_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              infl_q, infl_d;
    logic [2:0]        infl_mk_q, infl_mk_d;
    entry_t            fifo_q [2];
    entry_t            fifo_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;

    entry_t head;
    logic   pop, push, rd, last_x, last_y, credit_ok;

    assign head      = fifo_q[rd_ptr_q];
    assign pix_valid = (count_q != 2'd0);
    assign pix_data  = head.data;
    assign pix_sof   = pix_valid & head.sof;
    assign pix_eol   = pix_valid & head.eol;
    assign pix_eof   = pix_valid & head.eof;
    assign busy      = busy_q;
    assign done      = done_q;

    assign pop    = pix_valid & pix_ready;
    assign push   = infl_q;
    assign last_x = (x_q == width_q - 1'b1);
    assign last_y = (y_q == height_q - 1'b1);
    // Buffered plus in-flight entries, less this cycle's pop, must leave room for one more.
    assign credit_ok = ({1'b0, count_q} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop});
    assign rd        = (state_q == ISSUE) && !abort && credit_ok;

    assign mem_rd_en = rd;
    assign mem_addr  = row_q + ADDR_W'(x_q);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path infers a latch.
        state_d   = state_q;
        row_d     = row_q;
        stride_d  = stride_q;
        width_d   = width_q;
        height_d  = height_q;
        x_d       = x_q;
        y_d       = y_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        infl_d    = rd;
        infl_mk_d = {(x_q == '0) && (y_q == '0), last_x, last_x && last_y};
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q + {1'b0, push} - {1'b0, pop};

        if (push) begin
            fifo_d[wr_ptr_q] = '{sof: infl_mk_q[2], eol: infl_mk_q[1], eof: infl_mk_q[0],
                                 data: mem_rdata};
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (cfg_width != '0 && cfg_height != '0) begin
                        row_d    = cfg_base;
                        stride_d = cfg_stride;
                        width_d  = cfg_width;
                        height_d = cfg_height;
                        x_d      = '0;
                        y_d      = '0;
                        busy_d   = 1'b1;
                        state_d  = ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (rd) begin
                    if (last_x) begin
                        x_d   = '0;
                        y_d   = y_q + 1'b1;
                        row_d = row_q + stride_q;
                        if (last_y) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (pop && head.eof) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && abort) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            infl_d   = 1'b0;
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            stride_q  <= '0;
            width_q   <= '0;
            height_q  <= '0;
            x_q       <= '0;
            y_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            infl_q    <= 1'b0;
            infl_mk_q <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            // NOTE: the two buffer entries are reset so pix_data reads 0 out of reset.
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            stride_q  <= stride_d;
            width_q   <= width_d;
            height_q  <= height_d;
            x_q       <= x_d;
            y_q       <= y_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            infl_q    <= infl_d;
            infl_mk_q <= infl_mk_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            fifo_q    <= fifo_d;
        end
    end

endmodule

// File: tb/tb_ext_mem_frame_reader.sv
// Scoreboard bench for ext_mem_frame_reader: expected addresses and pixels are queued
// at start and popped as the DUT issues reads and hands off pixels.
module tb_ext_mem_frame_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] cfg_base = '0;
    logic [8:0]  cfg_width = '0;
    logic [8:0]  cfg_height = '0;
    logic [15:0] cfg_stride = '0;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = '0;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sof, pix_eol, pix_eof;
    logic        busy, done;

    ext_mem_frame_reader dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_base(cfg_base), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_stride(cfg_stride), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_val(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    // Memory model with a fixed one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem_val(mem_addr);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Ready driver: 0 = held low, 1 = held high, 2 = repeating 1,0,0,1.
    int         ready_mode = 0;
    int         tog_i = 0;
    logic [3:0] tog_pat = 4'b1001;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       pix_ready = 1'b0;
            1:       pix_ready = 1'b1;
            default: begin
                pix_ready = tog_pat[tog_i];
                tog_i = (tog_i + 1) % 4;
            end
        endcase
    end

    logic [15:0] exp_addr [$];
    logic [10:0] exp_pix  [$];

    int start_cyc = 0, first_rd_cyc = -1, last_rd_cyc = -1, first_valid_cyc = -1;
    int eof_pop_cyc = -1, done_cyc = -1;
    int rd_count = 0, done_count = 0, frame_rd = 0, frame_pop = 0;
    logic        prev_stall = 1'b0, prev_abort = 1'b0;
    logic [10:0] prev_pix = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (start && !busy && !abort) begin
                start_cyc = cyc;
                first_rd_cyc = -1;
                first_valid_cyc = -1;
                frame_rd = 0;
                frame_pop = 0;
            end
            if (prev_stall && !prev_abort) begin
                check("stall_valid", 32'(pix_valid), 32'd1);
                check("stall_hold", 32'({pix_sof, pix_eol, pix_eof, pix_data}), 32'(prev_pix));
            end
            if (mem_rd_en) begin
                rd_count++;
                frame_rd++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                last_rd_cyc = cyc;
                if (exp_addr.size() == 0) check("unexpected_read", 32'(mem_addr), 32'hFFFF_FFFF);
                else check("mem_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
            end
            if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (pix_valid && pix_ready) begin
                frame_pop++;
                if (pix_eof) eof_pop_cyc = cyc;
                if (exp_pix.size() == 0)
                    check("unexpected_pixel", 32'({pix_sof, pix_eol, pix_eof, pix_data}), 32'hFFFF_FFFF);
                else
                    check("pixel", 32'({pix_sof, pix_eol, pix_eof, pix_data}), 32'(exp_pix.pop_front()));
            end
            if (mem_rd_en) check("reads_ahead_le2", 32'((frame_rd - frame_pop) <= 2), 32'd1);
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
            prev_stall = pix_valid && !pix_ready;
            prev_abort = abort;
            prev_pix   = {pix_sof, pix_eol, pix_eof, pix_data};
        end
    end

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [15:0] base, input int w, input int h,
                               input logic [15:0] stride, input bit with_abort);
        @(posedge clk);
        #1;
        cfg_base   = base;
        cfg_width  = 9'(w);
        cfg_height = 9'(h);
        cfg_stride = stride;
        start      = 1'b1;
        abort      = with_abort;
        if (!with_abort) begin
            for (int y = 0; y < h; y++) begin
                for (int x = 0; x < w; x++) begin
                    logic [15:0] a;
                    a = 16'(int'(base) + y * int'(stride) + x);
                    exp_addr.push_back(a);
                    exp_pix.push_back({(x == 0 && y == 0), (x == w - 1),
                                       (x == w - 1 && y == h - 1), mem_val(a)});
                end
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_done(input int dc0, input int budget);
        for (int i = 0; i < budget; i++) begin
            sample();
            if (done_count > dc0) return;
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic end_of_frame(input string tag, input int dc0);
        repeat (3) sample();
        check({tag, "_done_once"}, 32'(done_count - dc0), 32'd1);
        check({tag, "_addr_left"}, 32'(exp_addr.size()), 32'd0);
        check({tag, "_pix_left"}, 32'(exp_pix.size()), 32'd0);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc0, rc0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        sample();
        check("reset_outputs",
              32'({mem_rd_en, pix_valid, pix_sof, pix_eol, pix_eof, busy, done, pix_data}), 32'd0);

        // 4x3 window, continuous ready: latency, back-to-back addresses, markers.
        ready_mode = 1;
        dc0 = done_count;
        start_frame(16'h0100, 4, 3, 16'd256, 1'b0);
        sample();
        check("t1_busy", 32'(busy), 32'd1);
        wait_done(dc0, 100);
        check("t1_first_rd_lat", 32'(first_rd_cyc - start_cyc), 32'd1);
        check("t1_first_valid_lat", 32'(first_valid_cyc - start_cyc), 32'd3);
        check("t1_reads_consecutive", 32'(last_rd_cyc - first_rd_cyc), 32'd11);
        check("t1_done_after_eof", 32'(done_cyc - eof_pop_cyc), 32'd1);
        end_of_frame("t1", dc0);

        // Same frame with ready toggling; a start pulse mid-frame must be ignored.
        ready_mode = 2;
        tog_i = 0;
        dc0 = done_count;
        start_frame(16'h0100, 4, 3, 16'd256, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        cfg_base = 16'h7777; cfg_width = 9'd2; cfg_height = 9'd2; cfg_stride = 16'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(dc0, 200);
        end_of_frame("t2", dc0);

        // 1x1 frame at the top of memory.
        ready_mode = 1;
        dc0 = done_count;
        rc0 = rd_count;
        start_frame(16'hFFFF, 1, 1, 16'd1, 1'b0);
        wait_done(dc0, 50);
        check("t3_one_read", 32'(rd_count - rc0), 32'd1);
        end_of_frame("t3", dc0);

        // 3x2 window whose addresses wrap past 0xFFFF.
        dc0 = done_count;
        start_frame(16'hFFFE, 3, 2, 16'd4, 1'b0);
        wait_done(dc0, 50);
        end_of_frame("t4", dc0);

        // Zero height: immediate done, no reads, never busy.
        dc0 = done_count;
        rc0 = rd_count;
        start_frame(16'h0200, 4, 0, 16'd8, 1'b0);
        check("t5_busy_low", 32'(busy), 32'd0);
        repeat (3) sample();
        check("t5_done_once", 32'(done_count - dc0), 32'd1);
        check("t5_done_lat", 32'(done_cyc - start_cyc), 32'd1);
        check("t5_no_reads", 32'(rd_count - rc0), 32'd0);

        // Abort and start in the same idle cycle: abort wins.
        dc0 = done_count;
        rc0 = rd_count;
        start_frame(16'h0300, 2, 2, 16'd2, 1'b1);
        check("t6_busy_low", 32'(busy), 32'd0);
        repeat (4) sample();
        check("t6_no_reads", 32'(rd_count - rc0), 32'd0);
        check("t6_no_done", 32'(done_count - dc0), 32'd0);

        // Abort an 8x8 frame after 5 pixels with ready held low.
        dc0 = done_count;
        start_frame(16'h1000, 8, 8, 16'd16, 1'b0);
        for (int i = 0; i < 100 && frame_pop < 5; i++) sample();
        check("t7_five_pixels", 32'(frame_pop), 32'd5);
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        exp_addr.delete();
        exp_pix.delete();
        sample();
        check("t7_valid_low", 32'(pix_valid), 32'd0);
        check("t7_busy_low", 32'(busy), 32'd0);
        rc0 = rd_count;
        repeat (4) sample();
        check("t7_no_done", 32'(done_count - dc0), 32'd0);
        check("t7_no_reads", 32'(rd_count - rc0), 32'd0);

        // Fresh frame after the abort starts again at pixel (0,0) with sof.
        ready_mode = 1;
        dc0 = done_count;
        start_frame(16'h1000, 8, 8, 16'd16, 1'b0);
        wait_done(dc0, 300);
        end_of_frame("t8", dc0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ext_mem_frame_reader.md
Name: ext_mem_frame_reader

Overview:
- Read controller for the 64K x 8-bit external pixel memory.
- Latches a rectangular window descriptor (base, width, height, stride) on start and issues one raster-order read per cycle.
- Absorbs the memory's fixed 1-cycle read latency in a 2-entry output buffer.
- Presents pixels on a valid/ready stream with frame/line markers to the downstream filter pipeline.

Parameters:
- ADDR_W, 16, memory address width; all address arithmetic wraps modulo 2^ADDR_W.
- DATA_W, 8, pixel width.
- DIM_W, 9, width/height field width (values 0..256).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a frame; sampled only in IDLE.
- abort  input  1  cancel the current frame.
- cfg_base  input  ADDR_W  address of window pixel (0,0).
- cfg_width  input  DIM_W  pixels per row.
- cfg_height  input  DIM_W  rows.
- cfg_stride  input  ADDR_W  address step between rows.
- mem_rd_en  output  1  read strobe.
- mem_addr  output  ADDR_W  read address, valid while mem_rd_en.
- mem_rdata  input  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
- pix_data  output  DATA_W  pixel value.
- pix_valid  output  1  pix_data/markers valid.
- pix_ready  input  1  downstream accept.
- pix_sof  output  1  first pixel of frame.
- pix_eol  output  1  last pixel of a row.
- pix_eof  output  1  last pixel of frame.
- busy  output  1  high from start acceptance until done or abort.
- done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset: all outputs 0, FIFO empty, in-flight flag cleared, state IDLE. Reset mid-frame discards everything with no done pulse.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - start=1 with width>0 and height>0: latch cfg_*, clear x/y, set busy, go to ISSUE.
  - start=1 with width or height 0: pulse done next cycle with no reads; busy stays 0.
  - start is ignored in ISSUE and DRAIN.
- ISSUE:
  - pop = pix_valid & pix_ready.
  - A read is issued in a cycle iff (fifo_count + inflight − pop) < 2. This gives one read per cycle under continuous ready.
  - mem_addr = base + y*stride + x (mod 2^ADDR_W). Use an incrementing row-start register; no multiplier.
  - x increments per read; at x = width−1, x←0 and y increments.
  - After the read of (width−1, height−1), go to DRAIN.
- DRAIN: no reads. When FIFO is empty and inflight=0 after the last pop, pulse done for one cycle, clear busy, go to IDLE.
- Data path:
  - inflight is set by a read and cleared the next cycle, when mem_rdata is written into the FIFO together with its sof/eol/eof markers, computed at issue time.
  - FIFO depth is 2; outputs come from the head entry.
  - The credit rule guarantees no overflow. Push and pop in the same cycle are both honoured.
- Latency: start sampled in cycle T → first mem_rd_en in T+1 → first pix_valid in T+3.
- Stall: with pix_ready=0, at most 2 reads are outstanding/buffered. pix_data and markers are held stable while pix_valid=1 and pix_ready=0.
- Markers:
  - pix_sof only on pixel (0,0).
  - pix_eol on x = width−1.
  - pix_eof on the last pixel.
  - A 1x1 frame asserts all three on its single pixel.
- done: asserted the cycle after the eof pixel's handshake.
- abort (any non-IDLE state):
  - next cycle: FIFO flushed, inflight data dropped, pix_valid=0, busy=0, state IDLE, no done pulse.
  - abort and start in the same IDLE cycle: abort wins and start is ignored.
- Address wrap: base + offset beyond 0xFFFF wraps to low addresses with no error.

Test Plan:
- 4x3 window, base 0x0100, stride 256, pix_ready=1 → addresses 0x0100..0x0103, 0x0200..0x0203, 0x0300..0x0303 on consecutive cycles; 12 pixels equal to memory contents; sof on pixel 0; eol on pixels 3, 7, 11; eof on pixel 11; done the cycle after; first pix_valid at T+3.
- Same frame, pix_ready toggling 1,0,0,1 → every pixel delivered exactly once in order; data stable during stalls; never more than 2 reads ahead of consumption.
- 1x1 frame at base 0xFFFF → single read of 0xFFFF; sof=eol=eof=1 on the one pixel; done pulses.
- Width 3, height 2, base 0xFFFE, stride 4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0002, 0x0003, 0x0004.
- Start with height=0 → done pulses at T+1; no mem_rd_en; busy stays 0. Start pulsed while busy → ignored; frame unchanged.
- Abort after 5 pixels of an 8x8 frame with pix_ready=0 → next cycle pix_valid=0, busy=0, no done. A following start runs a full fresh frame from pixel (0,0) with sof.
